tpu_host_seq: RTL and testbench
===============================

Name: tpu_host_seq

Overview:
- Bus initiator that drives the TPU memory-mapped slave port (r_w/addr/data) through one full matrix-multiply job.
- Takes A and B rows from an input stream, writes them to the TPU A and B windows, issues the start write and waits out the compute window.
- Then reads back every C half-row and emits it on an output stream with backpressure.
- Sits between the host-side DMA/stream fabric and the TPU.

Parameters:
- DIM, 8, matrix dimension; A/B rows per job, C has 2*DIM half-row words
- ADDRW, 16, TPU address width
- DATAW, 64, TPU/stream data width
- WAIT_CYCLES, 3*DIM, idle cycles after the start write before the first C read (must be >= 3*DIM-1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job request, sampled only in IDLE
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last C word is accepted
- in_data  in  DATAW  A rows then B rows, 8 signed 8-bit lanes, lane i = bits 8i+7:8i
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- out_data  out  DATAW  C half-row, 4 signed 16-bit lanes
- out_valid  out  1  out_data valid; held until accepted
- out_ready  in  1  consumer ready
- tpu_r_w  out  1  1=write, 0=read
- tpu_addr  out  ADDRW  TPU address
- tpu_wdata  out  DATAW  to TPU dataIn
- tpu_rdata  in  DATAW  from TPU dataOut, valid exactly one cycle after a read address

Behaviour:
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, tpu_r_w=0, tpu_addr=0, tpu_wdata=0. State=IDLE, all counters 0.
- All tpu_* outputs are registered.
- Idle bus cycle: r_w=0, addr=0, wdata=0. Every non-transfer cycle is an idle bus cycle, because the TPU acts on any r_w=1 cycle.
- IDLE: in_ready=0. start=1 -> LOAD_A, idx=0. start in any other state is ignored.
- LOAD_A: in_ready=1. On accept, next cycle drive r_w=1, addr=0x100+8*idx, wdata=in_data, then idx++. in_valid=0 gives an idle bus cycle and idx does not advance. After idx=DIM-1 -> LOAD_B with idx=0.
- LOAD_B: same as LOAD_A with addr=0x200+8*idx. After the last row: CLEAR_C if the feature is enabled, otherwise START.
- START: in_ready=0. One cycle of r_w=1, addr=0x400, wdata=0. Then WAIT with wcnt=0.
- WAIT: idle bus for WAIT_CYCLES cycles. Then RD_ISSUE with k=0.
- RD_ISSUE: one cycle of r_w=0, addr=0x300+16*(k>>1)+8*(k&1); k even = lanes 0-3 (low half), k odd = lanes 4-7. Then RD_CAP.
- RD_CAP: out_data<=tpu_rdata, out_valid<=1. Then RD_HOLD.
- RD_HOLD: on out_valid && out_ready: out_valid<=0; if k=2*DIM-1 -> DONE, else k++ -> RD_ISSUE. At most one read outstanding. Minimum 3 cycles per C word.
- DONE: done=1 for one cycle, busy falls in the same cycle, then IDLE.
- Word counts per job: exactly DIM A words and DIM B words consumed, exactly 2*DIM C words produced.
- Extra input words beyond the job are not consumed (in_ready=0).
- Reset mid-job: immediate return to reset values. A partial TPU load is left as-is; the next job overwrites A and B.
- Counters are sized to $clog2(2*DIM)+1 bits and never wrap within a job.

Optional Feature:
- Macro TPU_SEQ_CLEAR_C_EN.
- Defined: CLEAR_C state between LOAD_B and START. It issues 2*DIM back-to-back writes, r_w=1, addr=0x300+8*j (j=0..2*DIM-1), wdata=0, so C starts at zero every job.
- Not defined: no C writes; the TPU accumulates onto the existing C contents.

Test Plan:
- Reset mid-LOAD_B (after 3 B rows) -> all outputs at reset values next cycle; a subsequent full job completes with correct results.
- A=identity, B row r = lanes {r,r+1,...,r+7}, CLEAR_C_EN defined -> 16 out words; word 2r = {r..r+3} and word 2r+1 = {r+4..r+7} as 16-bit lanes; done pulses once.
- in_valid toggled 1/0 every cycle during loads -> exactly 16 writes observed, addresses 0x100..0x138 then 0x200..0x238, with r_w=0 on the gap cycles.
- out_ready held low for 10 cycles on word 5 -> out_data stable and out_valid high throughout; no new read issued until the word is accepted.
- Check the start write to 0x400, then exactly WAIT_CYCLES=24 idle bus cycles before the first read at 0x300; start pulsed while busy -> ignored.
- Feature undefined, same job run twice -> no writes to 0x300-0x37F; second job results = 2x first.

Source files
------------

// File: rtl/tpu_host_seq.sv
// Bus initiator that loads A/B into the TPU, starts it and streams C back out.
// Optional C pre-clear before start is enabled with `define TPU_SEQ_CLEAR_C_EN.
`timescale 1ns/1ps
module tpu_host_seq #(
    parameter int DIM         = 8,
    parameter int ADDRW       = 16,
    parameter int DATAW       = 64,
    parameter int WAIT_CYCLES = 3*DIM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [DATAW-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_wdata,
    input  logic [DATAW-1:0] tpu_rdata
);

    localparam int CW = $clog2(2*DIM) + 1;
    localparam int WW = $clog2(WAIT_CYCLES + 1) + 1;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD_A   = 4'd1;
    localparam logic [3:0] S_LOAD_B   = 4'd2;
    localparam logic [3:0] S_START    = 4'd4;
    localparam logic [3:0] S_WAIT     = 4'd5;
    localparam logic [3:0] S_RD_ISSUE = 4'd6;
    localparam logic [3:0] S_RD_CAP   = 4'd7;
    localparam logic [3:0] S_RD_HOLD  = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;
`ifdef TPU_SEQ_CLEAR_C_EN
    localparam logic [3:0] S_CLEAR_C  = 4'd3;
    localparam logic [3:0] S_AFTER_B  = S_CLEAR_C;
`else
    localparam logic [3:0] S_AFTER_B  = S_START;
`endif

    localparam logic [ADDRW-1:0] A_BASE  = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] B_BASE  = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] C_BASE  = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] GO_ADDR = ADDRW'(16'h0400);

    localparam logic [CW-1:0] LAST_ROW = CW'(DIM - 1);
    localparam logic [CW-1:0] LAST_K   = CW'(2*DIM - 1);
    localparam logic [WW-1:0] LAST_W   = WW'(WAIT_CYCLES);

    logic [3:0]       state, state_n;
    logic [CW-1:0]    idx, idx_n;
    logic [CW-1:0]    k, k_n;
    logic [WW-1:0]    wcnt, wcnt_n;
    logic             rw_n;
    logic [ADDRW-1:0] addr_n;
    logic [DATAW-1:0] wdata_n;
    logic             ov_n;
    logic [DATAW-1:0] od_n;

    assign in_ready = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);

    // Next-state and next bus cycle; the bus defaults to an idle cycle.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        k_n     = k;
        wcnt_n  = wcnt;
        rw_n    = 1'b0;
        addr_n  = '0;
        wdata_n = '0;
        ov_n    = out_valid;
        od_n    = out_data;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD_A;
                    idx_n   = '0;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (in_valid) begin
                    rw_n    = 1'b1;
                    addr_n  = ((state == S_LOAD_A) ? A_BASE : B_BASE)
                              + ADDRW'({idx, 3'b000});
                    wdata_n = in_data;
                    if (idx == LAST_ROW) begin
                        idx_n   = '0;
                        state_n = (state == S_LOAD_A) ? S_LOAD_B : S_AFTER_B;
                    end else begin
                        idx_n = idx + CW'(1);
                    end
                end
            end
`ifdef TPU_SEQ_CLEAR_C_EN
            S_CLEAR_C: begin
                rw_n   = 1'b1;
                addr_n = C_BASE + ADDRW'({idx, 3'b000});
                if (idx == LAST_K) begin
                    idx_n   = '0;
                    state_n = S_START;
                end else begin
                    idx_n = idx + CW'(1);
                end
            end
`endif
            S_START: begin
                rw_n    = 1'b1;
                addr_n  = GO_ADDR;
                wcnt_n  = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt == LAST_W) begin
                    k_n     = '0;
                    addr_n  = C_BASE;
                    state_n = S_RD_ISSUE;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end
            S_RD_ISSUE: begin
                state_n = S_RD_CAP;
            end
            S_RD_CAP: begin
                od_n    = tpu_rdata;
                ov_n    = 1'b1;
                state_n = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                if (out_valid && out_ready) begin
                    ov_n = 1'b0;
                    if (k == LAST_K) begin
                        state_n = S_DONE;
                    end else begin
                        k_n     = k + CW'(1);
                        addr_n  = C_BASE + ADDRW'({k + CW'(1), 3'b000});
                        state_n = S_RD_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Register FSM, counters, bus and output stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            k         <= '0;
            wcnt      <= '0;
            tpu_r_w   <= 1'b0;
            tpu_addr  <= '0;
            tpu_wdata <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            k         <= k_n;
            wcnt      <= wcnt_n;
            tpu_r_w   <= rw_n;
            tpu_addr  <= addr_n;
            tpu_wdata <= wdata_n;
            out_valid <= ov_n;
            out_data  <= od_n;
        end
    end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Directed bench for tpu_host_seq with a behavioural TPU slave.
// Runs load/compute/readback jobs incl. stall, mid-job reset, and accumulate.
`timescale 1ns/1ps
module tb_tpu_host_seq;

    localparam int WC = 24;
`ifdef TPU_SEQ_CLEAR_C_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        tpu_r_w;
    logic [15:0] tpu_addr;
    logic [63:0] tpu_wdata;
    logic [63:0] tpu_rdata = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tpu_host_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tpu_r_w   (tpu_r_w),
        .tpu_addr  (tpu_addr),
        .tpu_wdata (tpu_wdata),
        .tpu_rdata (tpu_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Input rows: 0..7 identity A, 8..15 B row r lanes r..r+7.
    function automatic logic [63:0] in_row(input int n);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            if (n < 8) w[8*i +: 8] = (i == n) ? 8'd1 : 8'd0;
            else       w[8*i +: 8] = 8'(n - 8 + i);
        end
        return w;
    endfunction

    function automatic logic [15:0] ld_addr(input int n);
        return (n < 8) ? 16'(32'h100 + 8*n) : 16'(32'h200 + 8*(n-8));
    endfunction

    function automatic logic [63:0] exp_word(input int k, input int m);
        logic [63:0] w;
        int r, h;
        r = k / 2;
        h = k % 2;
        for (int j = 0; j < 4; j++) w[16*j +: 16] = 16'(m * (r + 4*h + j));
        return w;
    endfunction

    // Behavioural TPU slave.
    logic [7:0]  am [8][8] = '{default: '0};
    logic [7:0]  bm [8][8] = '{default: '0};
    logic [15:0] cm [8][8] = '{default: '0};

    function automatic logic [15:0] dotp(input int r, input int c);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++)
            s += int'($signed(am[r][i])) * int'($signed(bm[i][c]));
        return 16'(s);
    endfunction

    function automatic logic [63:0] cword(input logic [3:0] kk);
        logic [63:0] w;
        for (int j = 0; j < 4; j++)
            w[16*j +: 16] = cm[int'(kk[3:1])][4*int'(kk[0]) + j];
        return w;
    endfunction

    always @(posedge clk) begin
        if (tpu_r_w) begin
            if (tpu_addr[15:8] == 8'h01)
                for (int i = 0; i < 8; i++)
                    am[tpu_addr[5:3]][i] <= tpu_wdata[8*i +: 8];
            if (tpu_addr[15:8] == 8'h02)
                for (int i = 0; i < 8; i++)
                    bm[tpu_addr[5:3]][i] <= tpu_wdata[8*i +: 8];
            if (tpu_addr[15:8] == 8'h03)
                for (int j = 0; j < 4; j++)
                    cm[tpu_addr[6:4]][4*int'(tpu_addr[3]) + j]
                        <= tpu_wdata[16*j +: 16];
            if (tpu_addr == 16'h0400)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        cm[r][c] <= cm[r][c] + dotp(r, c);
            tpu_rdata <= '0;
        end else if (tpu_addr[15:8] == 8'h03) begin
            tpu_rdata <= cword(tpu_addr[6:3]);
        end else begin
            tpu_rdata <= '0;
        end
    end

    // Per-job observation state, owned by the monitor.
    int   ld_wr, c_wr, st_wr, rd_cnt, words, done_cnt, idle_cnt;
    bit   in_wait, prev_acc, prev_ov, prev_or;
    logic [63:0] prev_od;
    logic ldw;
    int   mult = 1;
    bit   stall_en = 1'b0;
    int   hold = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n || (start && !busy)) begin
                ld_wr = 0; c_wr = 0; st_wr = 0; rd_cnt = 0;
                words = 0; done_cnt = 0; idle_cnt = 0;
                in_wait = 0; prev_acc = 0; prev_ov = 0; prev_or = 0;
                prev_od = '0;
            end else begin
                ldw = tpu_r_w && (tpu_addr[15:8] == 8'h01 ||
                                  tpu_addr[15:8] == 8'h02);
                if (prev_acc) chk("acc_wr", 64'(ldw), 64'd1);
                if (ldw) begin
                    chk("ld_after_acc", 64'(prev_acc), 64'd1);
                    chk("ld_addr", 64'(tpu_addr), 64'(ld_addr(ld_wr)));
                    chk("ld_data", tpu_wdata, in_row(ld_wr));
                    ld_wr++;
                end
                if (in_ready && !prev_acc) begin
                    chk("gap_rw", 64'(tpu_r_w), 64'd0);
                    chk("gap_addr", 64'(tpu_addr), 64'd0);
                end
                if (tpu_r_w && tpu_addr[15:8] == 8'h03) begin
                    chk("clr_addr", 64'(tpu_addr), 64'(32'h300 + 8*c_wr));
                    chk("clr_data", tpu_wdata, 64'd0);
                    c_wr++;
                end
                if (tpu_r_w && tpu_addr == 16'h0400) begin
                    st_wr++;
                    in_wait = 1;
                    idle_cnt = 0;
                end else if (in_wait) begin
                    if (!tpu_r_w && tpu_addr == 0 && tpu_wdata == 0) begin
                        idle_cnt++;
                    end else begin
                        chk("wait_idle", 64'(idle_cnt), 64'(WC));
                        chk("rd0_addr", 64'({tpu_r_w, tpu_addr}), 64'h300);
                        in_wait = 0;
                    end
                end
                if (!tpu_r_w && tpu_addr != 0) begin
                    chk("rd_addr", 64'(tpu_addr), 64'(32'h300 + 8*rd_cnt));
                    chk("rd_no_pend", 64'(out_valid), 64'd0);
                    rd_cnt++;
                end
                if (prev_ov && !prev_or) begin
                    chk("ov_hold", 64'(out_valid), 64'd1);
                    chk("od_hold", out_data, prev_od);
                end
                if (out_valid && out_ready) begin
                    chk("c_word", out_data, exp_word(words % 16, mult));
                    words++;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_words", 64'(words), 64'd16);
                    chk("busy_at_done", 64'(busy), 64'd0);
                end
                prev_acc = in_valid && in_ready;
                prev_ov  = out_valid;
                prev_or  = out_ready;
                prev_od  = out_data;
            end
        end
    end

    // Consumer: holds word 5 for 10 cycles when stalling is enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_en && words == 5 && out_valid && hold < 10) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", 64'(busy), 64'd1);
    endtask

    task automatic send_words(input int n, input bit toggle);
        bit ok;
        for (int w = 0; w < n; w++) begin
            in_data  = in_row(w);
            in_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                if (in_ready) ok = 1'b1;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            if (!ok) chk("in_tmo", 64'(ok), 64'd1);
            if (toggle) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 3000 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic job_checks();
        chk("ld_cnt", 64'(ld_wr), 64'd16);
        chk("c_wr_cnt", 64'(c_wr), 64'(16*CLR));
        chk("st_cnt", 64'(st_wr), 64'd1);
        chk("rd_cnt", 64'(rd_cnt), 64'd16);
        chk("words", 64'(words), 64'd16);
        chk("done_cnt", 64'(done_cnt), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ready", 64'(in_ready), 64'd0);
    endtask

    task automatic rst_checks(input string pfx);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
        chk({pfx, "_done"}, 64'(done), 64'd0);
        chk({pfx, "_rdy"}, 64'(in_ready), 64'd0);
        chk({pfx, "_ov"}, 64'(out_valid), 64'd0);
        chk({pfx, "_od"}, out_data, 64'd0);
        chk({pfx, "_rw"}, 64'(tpu_r_w), 64'd0);
        chk({pfx, "_addr"}, 64'(tpu_addr), 64'd0);
        chk({pfx, "_wd"}, tpu_wdata, 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_checks("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Job 1: toggled in_valid, start pulsed while busy.
        mult = 1;
        pulse_start();
        send_words(16, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        job_checks();

        // Job 2: back-to-back input, stall on word 5.
        mult = CLR ? 1 : 2;
        stall_en = 1'b1;
        pulse_start();
        send_words(16, 1'b0);
        wait_done();
        stall_en = 1'b0;
        job_checks();
        chk("stall_len", 64'(hold), 64'd10);

        // Job 3: reset after 3 B rows.
        pulse_start();
        send_words(11, 1'b0);
        rst_n = 1'b0;
        #1;
        rst_checks("mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Job 4: full job after the aborted one.
        mult = CLR ? 1 : 3;
        pulse_start();
        send_words(16, 1'b0);
        wait_done();
        job_checks();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
